// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Optional build macro: MDU_RADIX4_EN (two quotient bits per divider cycle).
package mult_div_unit_pkg;

  // ALU function codes acted on by the unit (MIPS32 SPECIAL funct field)
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    StIdle,
    StDivBusy,
    StDivDone
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Iterative unsigned restoring divider.
// Optional build macro: MDU_RADIX4_EN (two cascaded compare-subtract stages per cycle).
module mult_div_unit_div_core #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIV_CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

`ifdef MDU_RADIX4_EN
  localparam int unsigned Steps = DATA_W / 2;
`else
  localparam int unsigned Steps = DATA_W;
`endif
  localparam logic [DIV_CNT_W-1:0] LastCnt = DIV_CNT_W'(Steps - 1);

  logic [DATA_W-1:0]    rem_q, quot_q, dvsr_q;
  logic [DATA_W-1:0]    rem_d, quot_d;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic                 busy_q;

  // One restoring step on the {rem,quot} pair: shift left, conditionally subtract
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] r,
                                                   input logic [DATA_W-1:0] q,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W:0] t;
    logic [DATA_W:0] diff;
    t    = {r, q[DATA_W-1]};
    diff = t - {1'b0, d};
    if (t >= {1'b0, d}) begin
      return {diff[DATA_W-1:0], q[DATA_W-2:0], 1'b1};
    end
    return {t[DATA_W-1:0], q[DATA_W-2:0], 1'b0};
  endfunction

  // Next remainder/quotient for this cycle's step(s)
  always_comb begin
    logic [2*DATA_W-1:0] s1;
    s1 = div_step(rem_q, quot_q, dvsr_q);
`ifdef MDU_RADIX4_EN
    {rem_d, quot_d} = div_step(s1[2*DATA_W-1:DATA_W], s1[DATA_W-1:0], dvsr_q);
`else
    {rem_d, quot_d} = s1;
`endif
  end

  // Divider datapath and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dvsr_q <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  // High during the final step; results are valid after this edge
  assign done      = busy_q && (cnt_q == LastCnt);
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO, HI/LO for MFHI/MFLO.
// Optional build macro: MDU_RADIX4_EN (selects the radix-4 divider in div_core).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIV_CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              en,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall_req,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  mdu_state_e          state;
  logic                q_neg, r_neg;
  logic                is_sdiv, is_div, div_start;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic                core_busy, core_done;
  logic [DATA_W-1:0]   core_quot, core_rem, quot_fix, rem_fix;

  assign is_sdiv   = (funct == FUNCT_DIV);
  assign is_div    = is_sdiv || (funct == FUNCT_DIVU);
  assign div_start = (state == StIdle) && en && !flush && is_div && (op_b != '0);

  // DIVU feeds raw operands; DIV feeds magnitudes (|0x80000000| stays 0x80000000)
  assign a_abs = (is_sdiv && op_a[DATA_W-1]) ? -op_a : op_a;
  assign b_abs = (is_sdiv && op_b[DATA_W-1]) ? -op_b : op_b;

  assign prod_s = $signed({{DATA_W{op_a[DATA_W-1]}}, op_a}) *
                  $signed({{DATA_W{op_b[DATA_W-1]}}, op_b});
  assign prod_u = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};

  assign quot_fix = q_neg ? -core_quot : core_quot;
  assign rem_fix  = r_neg ? -core_rem : core_rem;

  mult_div_unit_div_core #(
    .DATA_W   (DATA_W),
    .DIV_CNT_W(DIV_CNT_W)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (flush),
    .dividend (a_abs),
    .divisor  (b_abs),
    .busy     (core_busy),
    .done     (core_done),
    .quotient (core_quot),
    .remainder(core_rem)
  );

  // Freeze request: issuing cycle of a divide plus every busy cycle
  always_comb begin
    stall_req = 1'b0;
    if (!rst && !flush) begin
      stall_req = div_start || (state == StDivBusy);
    end
  end

  // Control FSM with the architectural HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      hi    <= '0;
      lo    <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (flush) begin
      state <= StIdle;
    end else begin
      case (state)
        StIdle: begin
          if (en) begin
            case (funct)
              FUNCT_MULT:  {hi, lo} <= prod_s;
              FUNCT_MULTU: {hi, lo} <= prod_u;
              FUNCT_MTHI:  hi <= op_a;
              FUNCT_MTLO:  lo <= op_a;
              FUNCT_MFHI, FUNCT_MFLO: ;  // read combinationally through hi/lo
              FUNCT_DIV, FUNCT_DIVU: begin
                // Divide by zero leaves HI/LO untouched and does not stall
                if (op_b != '0) begin
                  q_neg <= is_sdiv && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                  r_neg <= is_sdiv && op_a[DATA_W-1];
                  state <= StDivBusy;
                end
              end
              default: ;
            endcase
          end
        end
        StDivBusy: begin
          if (core_done || !core_busy) begin
            state <= StDivDone;
          end
        end
        StDivDone: begin
          lo    <= quot_fix;
          hi    <= rem_fix;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
